round_sequencer: RTL and testbench

- Game-round controller for the binary number game: it sequences the 4-bit random generator and turns its output into timed rounds.
- Per round: enables the generator, latches a target value, waits for the player's 4-switch answer or a timeout, then scores the result.
- Sits between the generator, the switch/button front-end (already debounced, single-cycle submit pulse) and the display/score logic.

---
 rtl/binary_game_pkg.sv | 16 +
 rtl/round_timer.sv | 35 +++
 rtl/round_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_round_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_game_pkg.sv
// Shared types and widths for the binary number game round controller.
package binary_game_pkg;

    localparam int unsigned VALUE_W  = 4;
    localparam int unsigned ROUND_W  = 4;
    localparam int unsigned REDRAW_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        WAIT,
        JUDGE,
        DONE
    } state_e;

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter that stops at zero; expired_c flags a zero count.
module round_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired_c
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q == '0);

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: draws a target, waits for an answer or timeout, scores it.
// Optional NO_REPEAT_EN macro rejects a target equal to the previous round's target.
module round_sequencer
    import binary_game_pkg::*;
#(
    parameter int unsigned ROUND_TICKS = 1000,
    parameter int unsigned NUM_ROUNDS  = 10,
    parameter int unsigned GEN_SETTLE  = 2,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [VALUE_W-1:0] gen_result,
    output logic               gen_enable,
    input  logic [VALUE_W-1:0] answer,
    input  logic               submit,
    output logic [VALUE_W-1:0] target,
    output logic               target_valid,
    output logic [SCORE_W-1:0] score,
    output logic [ROUND_W-1:0] round_num,
    output logic               hit,
    output logic               miss,
    output logic               busy,
    output logic               game_over
);

    localparam int unsigned CNT_MAX = (ROUND_TICKS > GEN_SETTLE) ? ROUND_TICKS : GEN_SETTLE;
    localparam int unsigned TIMER_W = $clog2(CNT_MAX);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(GEN_SETTLE - 1);
    localparam logic [TIMER_W-1:0] ROUND_LOAD  = TIMER_W'(ROUND_TICKS - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS);

    state_e               state_d, state_q;
    logic [VALUE_W-1:0]   target_d, target_q;
    logic [SCORE_W-1:0]   score_d, score_q;
    logic [ROUND_W-1:0]   round_d, round_q;
    logic                 hit_d, hit_q;
    logic                 miss_d, miss_q;
    logic                 gen_enable_d, gen_enable_q;
    logic                 target_valid_d, target_valid_q;
    logic                 busy_d, busy_q;
    logic                 game_over_d, game_over_q;
    logic                 timer_load_c;
    logic [TIMER_W-1:0]   timer_val_c;
    logic                 timer_en_c;
    logic                 timer_done_c;
    logic                 accept_c;
`ifdef NO_REPEAT_EN
    logic [REDRAW_W-1:0]  redraw_d, redraw_q;
`endif

    // One counter serves both the DRAW settle window and the WAIT answer window.
    round_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_c),
        .load_val (timer_val_c),
        .en       (timer_en_c),
        .expired_c(timer_done_c)
    );

`ifdef NO_REPEAT_EN
    // A repeat is rejected until the redraw counter saturates, so a stuck generator still progresses.
    assign accept_c = (round_q == '0) || (gen_result != target_q) || (redraw_q == '1);
`else
    assign accept_c = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        score_d      = score_q;
        round_d      = round_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        timer_load_c = 1'b0;
        timer_val_c  = SETTLE_LOAD;
        timer_en_c   = 1'b0;
`ifdef NO_REPEAT_EN
        redraw_d     = redraw_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = DRAW;
                    score_d      = '0;
                    round_d      = '0;
                    timer_load_c = 1'b1;
                end
            end
            DRAW: begin
                timer_en_c = 1'b1;
                if (timer_done_c) begin
                    timer_load_c = 1'b1;
                    if (accept_c) begin
                        target_d    = gen_result;
                        state_d     = WAIT;
                        timer_val_c = ROUND_LOAD;
`ifdef NO_REPEAT_EN
                        redraw_d    = '0;
                    end else begin
                        redraw_d    = redraw_q + REDRAW_W'(1);
`endif
                    end
                end
            end
            WAIT: begin
                timer_en_c = 1'b1;
                if (submit) begin
                    state_d = JUDGE;
                    hit_d   = (answer == target_q);
                    miss_d  = (answer != target_q);
                end else if (timer_done_c) begin
                    state_d = JUDGE;
                    miss_d  = 1'b1;
                end
            end
            JUDGE: begin
                if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    state_d      = DRAW;
                    timer_load_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Score and round count land together with the hit/miss pulse.
        if (hit_d && (score_q != '1)) begin
            score_d = score_q + SCORE_W'(1);
        end
        if (hit_d || miss_d) begin
            round_d = round_q + ROUND_W'(1);
        end

        gen_enable_d   = (state_d == DRAW);
        target_valid_d = (state_d == WAIT);
        busy_d         = (state_d == DRAW) || (state_d == WAIT) || (state_d == JUDGE);
        game_over_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            target_q       <= '0;
            score_q        <= '0;
            round_q        <= '0;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            gen_enable_q   <= 1'b0;
            target_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            game_over_q    <= 1'b0;
`ifdef NO_REPEAT_EN
            redraw_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            score_q        <= score_d;
            round_q        <= round_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            gen_enable_q   <= gen_enable_d;
            target_valid_q <= target_valid_d;
            busy_q         <= busy_d;
            game_over_q    <= game_over_d;
`ifdef NO_REPEAT_EN
            redraw_q       <= redraw_d;
`endif
        end
    end

    assign gen_enable   = gen_enable_q;
    assign target       = target_q;
    assign target_valid = target_valid_q;
    assign score        = score_q;
    assign round_num    = round_q;
    assign hit          = hit_q;
    assign miss         = miss_q;
    assign busy         = busy_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a stub generator stepping a value table per enable window.
module tb_round_sequencer;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] gen_result;
    logic       gen_enable;
    logic [3:0] answer = 4'd0;
    logic       submit = 1'b0;
    logic [3:0] target;
    logic       target_valid;
    logic [3:0] score;
    logic [3:0] round_num;
    logic       hit;
    logic       miss;
    logic       busy;
    logic       game_over;

    int total = 0;
    int bad = 0;

    logic [3:0] gen_tab [0:31];
    int         en_cnt;
    int         win_idx;

    always #5 clk = ~clk;

    round_sequencer #(
        .ROUND_TICKS(8),
        .NUM_ROUNDS (3),
        .GEN_SETTLE (SETTLE),
        .SCORE_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .gen_result  (gen_result),
        .gen_enable  (gen_enable),
        .answer      (answer),
        .submit      (submit),
        .target      (target),
        .target_valid(target_valid),
        .score       (score),
        .round_num   (round_num),
        .hit         (hit),
        .miss        (miss),
        .busy        (busy),
        .game_over   (game_over)
    );

    // Generator stub: each GEN_SETTLE enabled cycles form one window with its own table value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_cnt <= 0;
        else if (gen_enable) en_cnt <= en_cnt + 1;
    end

    always_comb begin
        win_idx    = (en_cnt / SETTLE > 31) ? 31 : en_cnt / SETTLE;
        gen_result = gen_tab[win_idx];
    end

    task step;
        @(negedge clk);
    endtask

    task test_reset;
        rst_n = 1'b0;
        repeat (3) step;
        total++;
        if ({gen_enable, target_valid, hit, miss, busy, game_over} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {gen_enable, target_valid, hit, miss, busy, game_over});
        end
        total++;
        if ({target, score, round_num} !== 12'h000) begin
            bad++;
            $display("FAIL reset_values: got %h want 000", {target, score, round_num});
        end
        rst_n = 1'b1;
        step;
    endtask

    task test_first_round;
        start = 1'b1;
        step;
        start = 1'b0;
        total++;
        if ({gen_enable, busy, target_valid} !== 3'b110) begin
            bad++;
            $display("FAIL draw_c1: got %b want 110", {gen_enable, busy, target_valid});
        end
        step;
        total++;
        if (gen_enable !== 1'b1) begin
            bad++;
            $display("FAIL draw_c2: got %b want 1", gen_enable);
        end
        step;
        total++;
        if ({gen_enable, target_valid, busy, target} !== {3'b011, 4'd5}) begin
            bad++;
            $display("FAIL wait_entry: got %b want 0110101", {gen_enable, target_valid, busy, target});
        end
        answer = 4'd5;
        submit = 1'b1;
        step;
        submit = 1'b0;
        total++;
        if ({hit, miss, target_valid, score, round_num} !== {3'b100, 4'd1, 4'd1}) begin
            bad++;
            $display("FAIL hit_r1: got %b want 10000010001", {hit, miss, target_valid, score, round_num});
        end
        step;
        total++;
        if ({hit, gen_enable} !== 2'b01) begin
            bad++;
            $display("FAIL redraw_r2: got %b want 01", {hit, gen_enable});
        end
    endtask

    task test_timeout;
        step;
        step;
        total++;
        if ({target_valid, target} !== {1'b1, 4'd9}) begin
            bad++;
            $display("FAIL wait_r2: got %b want 11001", {target_valid, target});
        end
        repeat (7) step;
        total++;
        if ({target_valid, miss} !== 2'b10) begin
            bad++;
            $display("FAIL last_tick_r2: got %b want 10", {target_valid, miss});
        end
        step;
        total++;
        if ({miss, hit, score, round_num} !== {2'b10, 4'd1, 4'd2}) begin
            bad++;
            $display("FAIL timeout_r2: got %b want 1000010010", {miss, hit, score, round_num});
        end
    endtask

    task test_submit_wins;
        step;
        step;
        step;
        total++;
        if ({target_valid, target} !== {1'b1, 4'd12}) begin
            bad++;
            $display("FAIL wait_r3: got %b want 11100", {target_valid, target});
        end
        repeat (7) step;
        answer = 4'd12;
        submit = 1'b1;
        step;
        submit = 1'b0;
        total++;
        if ({hit, miss, score, round_num} !== {2'b10, 4'd2, 4'd3}) begin
            bad++;
            $display("FAIL submit_wins: got %b want 1000100011", {hit, miss, score, round_num});
        end
        step;
        total++;
        if ({game_over, busy, target_valid, gen_enable, target} !== {4'b1000, 4'd12}) begin
            bad++;
            $display("FAIL done_state: got %b want 10001100", {game_over, busy, target_valid, gen_enable, target});
        end
    endtask

    task test_done_ignore;
        submit = 1'b1;
        step;
        submit = 1'b0;
        total++;
        if ({hit, miss, game_over, score} !== {3'b001, 4'd2}) begin
            bad++;
            $display("FAIL done_submit: got %b want 0010010", {hit, miss, game_over, score});
        end
    endtask

    task test_restart;
        start = 1'b1;
        step;
        start = 1'b0;
        total++;
        if ({score, round_num, gen_enable, game_over, busy} !== {8'h00, 3'b101}) begin
            bad++;
            $display("FAIL restart: got %b want 00000000101", {score, round_num, gen_enable, game_over, busy});
        end
        step;
        step;
        total++;
        if ({target_valid, target} !== {1'b1, 4'd3}) begin
            bad++;
            $display("FAIL restart_wait: got %b want 10011", {target_valid, target});
        end
        start = 1'b1;
        step;
        start = 1'b0;
        total++;
        if ({target_valid, gen_enable, round_num, score} !== {2'b10, 8'h00}) begin
            bad++;
            $display("FAIL start_busy: got %b want 1000000000", {target_valid, gen_enable, round_num, score});
        end
    endtask

    task test_mid_reset;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({gen_enable, target_valid, hit, miss, busy, game_over, target, score, round_num} !== 18'b0) begin
            bad++;
            $display("FAIL async_reset: got %b want 0",
                     {gen_enable, target_valid, hit, miss, busy, game_over, target, score, round_num});
        end
        step;
        rst_n = 1'b1;
        step;
        total++;
        if ({hit, miss, busy, target_valid, gen_enable} !== 5'b0) begin
            bad++;
            $display("FAIL after_reset: got %b want 00000", {hit, miss, busy, target_valid, gen_enable});
        end
    endtask

`ifdef NO_REPEAT_EN
    task test_no_repeat;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) gen_tab[i] = 4'd5;
        gen_tab[2] = 4'd7;
        step;
        rst_n = 1'b1;
        step;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        step;
        answer = 4'd5;
        submit = 1'b1;
        step;
        submit = 1'b0;
        repeat (4) step;
        total++;
        if ({gen_enable, target_valid} !== 2'b10) begin
            bad++;
            $display("FAIL redraw_held: got %b want 10", {gen_enable, target_valid});
        end
        step;
        total++;
        if ({target_valid, target} !== {1'b1, 4'd7}) begin
            bad++;
            $display("FAIL redraw_target: got %b want 10111", {target_valid, target});
        end
        rst_n = 1'b0;
        gen_tab[2] = 4'd5;
        step;
        rst_n = 1'b1;
        step;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        step;
        submit = 1'b1;
        step;
        submit = 1'b0;
        repeat (32) step;
        total++;
        if ({gen_enable, target_valid} !== 2'b10) begin
            bad++;
            $display("FAIL stuck_held: got %b want 10", {gen_enable, target_valid});
        end
        step;
        total++;
        if ({target_valid, target} !== {1'b1, 4'd5}) begin
            bad++;
            $display("FAIL stuck_accept: got %b want 10101", {target_valid, target});
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) gen_tab[i] = 4'd0;
        gen_tab[0] = 4'd5;
        gen_tab[1] = 4'd9;
        gen_tab[2] = 4'd12;
        gen_tab[3] = 4'd3;
        test_reset;
        test_first_round;
        test_timeout;
        test_submit_wins;
        test_done_ignore;
        test_restart;
        test_mid_reset;
`ifdef NO_REPEAT_EN
        test_no_repeat;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
